tile_map_sequencer: RTL
=======================

Name: tile_map_sequencer

Overview:
Initiator side of the 8x8 tile-draw handshake. On a frame start it walks the visible tile grid row-major, fetches each tile index from the tile-map ROM (with horizontal scroll applied), and issues one draw request per tile to the 8x8 tile drawer, waiting for that drawer's drawDone handshake before moving on. It sits between the game/scroll controller and the tile drawer, and signals frame_done when the whole screen has been issued.

Parameters:
SCREEN_COLS, 20, visible tile columns (20 x 8 = 160 px)
SCREEN_ROWS, 15, visible tile rows (15 x 8 = 120 px)
MAP_COLS_LOG2, 6, log2 of tile-map width in tiles (64-column map)
TILE_LOG2, 3, log2 of tile edge in pixels (8)

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a frame; ignored unless the block is in IDLE
scroll_col  in  MAP_COLS_LOG2  map column shown at screen column 0, sampled on start
drawDone  in  1  tile drawer status: high = drawer idle, low = drawer busy
rom_data  in  8  tile index returned by the map ROM one cycle after map_addr
map_addr  out  MAP_COLS_LOG2+4  map ROM address = {row[3:0], map_col}
draw  out  1  draw request to the tile drawer
tile_id  out  8  latched tile index for the current request
origin_x  out  8  screen x of the tile's top-left pixel = col << TILE_LOG2
origin_y  out  7  screen y of the tile's top-left pixel = row << TILE_LOG2
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after the last tile's drawDone returns high

Behaviour:
- Reset (async, resetn low): state = IDLE; row = 0; col = 0; scroll register = 0. All outputs are 0: draw, tile_id, origin_x, origin_y, map_addr, busy, frame_done.
- Counters: col runs 0..SCREEN_COLS-1 and row runs 0..SCREEN_ROWS-1.
- Scroll arithmetic: map_col = (scroll_reg + col) mod 2^MAP_COLS_LOG2, i.e. natural wrap, no carry into row. Example: scroll 60, col 5 -> map_col 1.
- origin_x and origin_y come straight from col and row. They stay stable from the LATCH cycle through the end of WAIT_DONE.
- Registered FSM:
  - IDLE: busy = 0. When start = 1: scroll_reg <= scroll_col, row <= 0, col <= 0, go to FETCH.
  - FETCH (1 cycle): drive map_addr; go to LATCH.
  - LATCH (1 cycle): tile_id <= rom_data; go to REQ.
  - REQ: draw = 1. Hold until drawDone is sampled 0 (drawer has accepted), then go to WAIT_DONE. draw deasserts on the cycle the state leaves REQ.
  - WAIT_DONE: draw = 0. Hold until drawDone is sampled 1.
    - Not the last tile: go to ADVANCE.
    - Last tile (row = SCREEN_ROWS-1 and col = SCREEN_COLS-1): go to FINISH.
  - ADVANCE (1 cycle):
    - If col = SCREEN_COLS-1: col <= 0 and row <= row+1.
    - Otherwise: col <= col+1.
    - Go to FETCH.
  - FINISH (1 cycle): frame_done = 1; go to IDLE.
- Handshake rules:
  - drawDone is high while the drawer is idle. A high level in REQ is therefore never treated as completion; completion means a low level followed by a high level.
  - draw may stay high for several cycles while waiting for acceptance. The drawer treats this as a single request.
- Timing: minimum per-tile overhead is 4 sequencer cycles (FETCH, LATCH, REQ, ADVANCE) plus the drawer's busy time.
- start while busy = 1 is ignored. scroll_col changes mid-frame have no effect until the next start.
- resetn asserted mid-frame: immediate return to IDLE with all outputs 0, including draw. There is no partial-frame resume.
- start and the FINISH cycle cannot overlap: start is only acted on in IDLE, so a start pulse during FINISH is dropped.

Test Plan:
1. Reset then idle: resetn low for 3 cycles, drawDone = 1 -> all outputs 0, busy = 0; start not pulsed -> state stays IDLE, draw never rises.
2. First tile with scroll: scroll_col = 0, start pulse, ROM returns 0x2A at addr 0 -> map_addr = 0 two cycles after start, tile_id = 0x2A, origin = (0,0), draw high until the drawer model drops drawDone.
3. Column wrap: scroll_col = 62, tile at col 3 -> map_addr = {row, 6'd1}, origin_x = 24.
4. Row advance: after col 19 of row 0 completes -> next map_addr = {4'd1, scroll}, origin = (0,8).
5. Full frame with a drawer model (busy 64 cycles per tile) -> exactly 300 draw requests; frame_done pulses once, one cycle after the 300th drawDone rises; busy then 0.
6. Robustness:
   - start pulsed mid-frame -> ignored, tile count unchanged.
   - resetn pulsed during WAIT_DONE of tile 50 -> draw = 0 and state IDLE immediately; a new start restarts at (0,0).
   - drawDone held high for 10 cycles in REQ -> draw stays high and no advance occurs.

Source files
------------

// File: rtl/tile_map_sequencer_if.sv
// Tile-draw request bus plus map ROM port shared by the
// sequencer (master) and the tile drawer / ROM side (slave).
interface tile_map_sequencer_if #(
    parameter int MAP_COLS_LOG2 = 6
);
    logic                     draw;
    logic                     drawDone;
    logic [7:0]               tile_id;
    logic [7:0]               origin_x;
    logic [6:0]               origin_y;
    logic [MAP_COLS_LOG2+3:0] map_addr;
    logic [7:0]               rom_data;

    modport master (
        output draw,
        output tile_id,
        output origin_x,
        output origin_y,
        output map_addr,
        input  drawDone,
        input  rom_data
    );

    modport slave (
        input  draw,
        input  tile_id,
        input  origin_x,
        input  origin_y,
        input  map_addr,
        output drawDone,
        output rom_data
    );
endinterface

// File: rtl/tile_map_sequencer.sv
// Walks the visible tile grid row-major, fetches scrolled tile
// indices from the map ROM and issues one draw per tile.
module tile_map_sequencer #(
    parameter int SCREEN_COLS   = 20,
    parameter int SCREEN_ROWS   = 15,
    parameter int MAP_COLS_LOG2 = 6,
    parameter int TILE_LOG2     = 3
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [MAP_COLS_LOG2-1:0] scroll_col,
    output logic                     busy,
    output logic                     frame_done,
    tile_map_sequencer_if.master     bus
);
    localparam int CW = 8 - TILE_LOG2;
    localparam int RW = 7 - TILE_LOG2;

    localparam logic [CW-1:0] LAST_COL = CW'(SCREEN_COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(SCREEN_ROWS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_REQ   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_ADV   = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    logic [2:0]               r_state;
    logic [CW-1:0]            r_col;
    logic [RW-1:0]            r_row;
    logic [MAP_COLS_LOG2-1:0] r_scroll;
    logic [7:0]               r_tile;

    logic                     w_last_col;
    logic                     w_last_row;
    logic [MAP_COLS_LOG2-1:0] w_map_col;

    assign w_last_col = (r_col == LAST_COL);
    assign w_last_row = (r_row == LAST_ROW);
    // Map column wraps naturally; no carry into the row field.
    assign w_map_col  = r_scroll + MAP_COLS_LOG2'(r_col);

    assign bus.map_addr = {r_row, w_map_col};
    assign bus.origin_x = {r_col, {TILE_LOG2{1'b0}}};
    assign bus.origin_y = {r_row, {TILE_LOG2{1'b0}}};
    assign bus.tile_id  = r_tile;
    assign bus.draw     = (r_state == S_REQ);
    assign busy         = (r_state != S_IDLE);
    assign frame_done   = (r_state == S_FIN);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_col    <= '0;
            r_row    <= '0;
            r_scroll <= '0;
            r_tile   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_scroll <= scroll_col;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_LATCH;
                S_LATCH: begin
                    r_tile  <= bus.rom_data;
                    r_state <= S_REQ;
                end
                // A high drawDone here is just an idle drawer, not completion.
                S_REQ: begin
                    if (!bus.drawDone) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.drawDone) begin
                        if (w_last_col && w_last_row) r_state <= S_FIN;
                        else                          r_state <= S_ADV;
                    end
                end
                S_ADV: begin
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    r_state <= S_FETCH;
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
